// File: rtl/lmc1992_pkg.sv
// Shared command codes, setting limits, reset defaults and the 2 dB/step
// attenuation table for the LMC1992 replacement.
package lmc1992_pkg;

    typedef enum logic [2:0] {
        CMD_MIXER  = 3'b000,
        CMD_BASS   = 3'b001,
        CMD_TREBLE = 3'b010,
        CMD_MASTER = 3'b011,
        CMD_RIGHT  = 3'b100,
        CMD_LEFT   = 3'b101,
        CMD_RSVD6  = 3'b110,
        CMD_RSVD7  = 3'b111
    } cmd_e;

    localparam logic [1:0] MW_ADDR    = 2'b10;
    localparam logic [5:0] MASTER_MAX = 6'd40;
    localparam logic [4:0] LR_MAX     = 5'd20;
    localparam logic [3:0] TONE_MAX   = 4'd12;

    typedef struct packed {
        logic [1:0] mixer;
        logic [3:0] bass;
        logic [3:0] treble;
        logic [5:0] master;
        logic [4:0] left;
        logic [4:0] right;
    } settings_t;

    localparam settings_t SETTINGS_RST = '{
        mixer:  2'b01,
        bass:   4'd6,
        treble: 4'd6,
        master: MASTER_MAX,
        left:   LR_MAX,
        right:  LR_MAX
    };

    function automatic logic [5:0] clamp(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // round(32768 * 10^(-k/10)); steps beyond 48 round to zero.
    function automatic logic [15:0] GAIN_LUT(input logic [5:0] steps);
        logic [15:0] g;
        case (steps)
            6'd0:  g = 16'd32768;  6'd1:  g = 16'd26029;  6'd2:  g = 16'd20675;
            6'd3:  g = 16'd16423;  6'd4:  g = 16'd13045;  6'd5:  g = 16'd10362;
            6'd6:  g = 16'd8231;   6'd7:  g = 16'd6538;   6'd8:  g = 16'd5193;
            6'd9:  g = 16'd4125;   6'd10: g = 16'd3277;   6'd11: g = 16'd2603;
            6'd12: g = 16'd2068;   6'd13: g = 16'd1642;   6'd14: g = 16'd1305;
            6'd15: g = 16'd1036;   6'd16: g = 16'd823;    6'd17: g = 16'd654;
            6'd18: g = 16'd519;    6'd19: g = 16'd413;    6'd20: g = 16'd328;
            6'd21: g = 16'd260;    6'd22: g = 16'd207;    6'd23: g = 16'd164;
            6'd24: g = 16'd130;    6'd25: g = 16'd104;    6'd26: g = 16'd82;
            6'd27: g = 16'd65;     6'd28: g = 16'd52;     6'd29: g = 16'd41;
            6'd30: g = 16'd33;     6'd31: g = 16'd26;     6'd32: g = 16'd21;
            6'd33: g = 16'd16;     6'd34: g = 16'd13;     6'd35: g = 16'd10;
            6'd36: g = 16'd8;      6'd37: g = 16'd7;      6'd38: g = 16'd5;
            6'd39: g = 16'd4;      6'd40: g = 16'd3;      6'd41: g = 16'd3;
            6'd42: g = 16'd2;      6'd43: g = 16'd2;      6'd44: g = 16'd1;
            6'd45: g = 16'd1;      6'd46: g = 16'd1;      6'd47: g = 16'd1;
            6'd48: g = 16'd1;
            default: g = 16'd0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/lmc1992_if.sv
// Microwire link from the STE DMA sound block (master) to the LMC1992 receiver (slave).
interface lmc1992_if;
    logic mw_clk;
    logic mw_data;
    logic mw_en;

    modport master (output mw_clk, output mw_data, output mw_en);
    modport slave  (input  mw_clk, input  mw_data, input  mw_en);
endinterface

// File: rtl/lmc1992_microwire_rx.sv
// Microwire deserialiser: clock edge detect, MSB-first shift register and a
// saturating bit counter; flags a full-length frame when mw_en drops.
module microwire_rx #(
    parameter int MW_BITS = 11
) (
    input  logic               clk_8,
    input  logic               reset,
    lmc1992_if.slave           mw,
    output logic               frame_valid,
    output logic [MW_BITS-1:0] frame_word
);

    logic               mw_clk_d;
    logic               mw_en_d;
    logic [MW_BITS-1:0] sr;
    logic [3:0]         cnt;
    logic               rise;
    logic               frame_end;

    assign rise      = mw.mw_clk & ~mw_clk_d;
    assign frame_end = ~mw.mw_en & mw_en_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_8) begin
        if (reset) begin
            mw_clk_d <= 1'b0;
            mw_en_d  <= 1'b0;
            sr       <= '0;
            cnt      <= '0;
        end else begin
            mw_clk_d <= mw.mw_clk;
            mw_en_d  <= mw.mw_en;
            if (frame_end) begin
                cnt <= '0;
            end else if (rise && mw.mw_en) begin
                sr <= {sr[MW_BITS-2:0], mw.mw_data};
                if (cnt != 4'hF) cnt <= cnt + 4'd1;
            end
        end
    end

    // Longer frames are accepted; sr then holds their last MW_BITS bits.
    assign frame_valid = frame_end && (cnt >= 4'(MW_BITS));
    assign frame_word  = sr;

endmodule

// File: rtl/lmc1992.sv
// LMC1992 replacement: microwire command decode, settings registers and the
// two-stage mix / attenuate audio pipeline feeding the sigma-delta DAC.
module lmc1992
    import lmc1992_pkg::*;
#(
    parameter int MW_BITS = 11,
    parameter int AW      = 15
) (
    input  logic                 clk_8,
    input  logic                 reset,
    lmc1992_if.slave             mw,
    input  logic signed [AW-1:0] ym_in_l,
    input  logic signed [AW-1:0] ym_in_r,
    input  logic signed [AW-1:0] ste_in_l,
    input  logic signed [AW-1:0] ste_in_r,
    output logic signed [AW-1:0] audio_out_l,
    output logic signed [AW-1:0] audio_out_r,
    output logic [3:0]           bass,
    output logic [3:0]           treble,
    output logic [1:0]           mixer,
    output logic                 cmd_strobe
);

    logic               frame_valid;
    logic [MW_BITS-1:0] frame_word;

    microwire_rx #(.MW_BITS(MW_BITS)) u_rx (
        .clk_8       (clk_8),
        .reset       (reset),
        .mw          (mw),
        .frame_valid (frame_valid),
        .frame_word  (frame_word)
    );

    logic [1:0] f_addr;
    cmd_e       f_cmd;
    logic [5:0] f_val;

    assign f_addr = frame_word[MW_BITS-1 -: 2];
    assign f_cmd  = cmd_e'(frame_word[MW_BITS-3 -: 3]);
    assign f_val  = frame_word[5:0];

    settings_t settings_q;
    settings_t settings_d;
    logic      strobe_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        settings_d = settings_q;
        strobe_d   = 1'b0;
        if (frame_valid && (f_addr == MW_ADDR)) begin
            strobe_d = 1'b1;
            unique case (f_cmd)
                CMD_MIXER:  settings_d.mixer  = f_val[1:0];
                CMD_BASS:   settings_d.bass   = 4'(clamp(f_val, {2'b00, TONE_MAX}));
                CMD_TREBLE: settings_d.treble = 4'(clamp(f_val, {2'b00, TONE_MAX}));
                CMD_MASTER: settings_d.master = clamp(f_val, MASTER_MAX);
                CMD_RIGHT:  settings_d.right  = 5'(clamp(f_val, {1'b0, LR_MAX}));
                CMD_LEFT:   settings_d.left   = 5'(clamp(f_val, {1'b0, LR_MAX}));
                default:    strobe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_8) begin
        if (reset) begin
            settings_q <= SETTINGS_RST;
            cmd_strobe <= 1'b0;
        end else begin
            settings_q <= settings_d;
            cmd_strobe <= strobe_d;
        end
    end

    assign bass   = settings_q.bass;
    assign treble = settings_q.treble;
    assign mixer  = settings_q.mixer;

    // Total attenuation in 2 dB steps; 0..60 by construction of the clamps.
    logic [5:0]  steps_l;
    logic [5:0]  steps_r;
    logic [15:0] gain_l_q;
    logic [15:0] gain_r_q;

    assign steps_l = (MASTER_MAX - settings_q.master) + {1'b0, LR_MAX - settings_q.left};
    assign steps_r = (MASTER_MAX - settings_q.master) + {1'b0, LR_MAX - settings_q.right};

    always_ff @(posedge clk_8) begin
        if (reset) begin
            gain_l_q <= GAIN_LUT(6'd0);
            gain_r_q <= GAIN_LUT(6'd0);
        end else begin
            gain_l_q <= GAIN_LUT(steps_l);
            gain_r_q <= GAIN_LUT(steps_r);
        end
    end

    function automatic logic signed [AW-1:0] mix_sat(
        input logic [1:0]           sel,
        input logic signed [AW-1:0] ym,
        input logic signed [AW-1:0] ste
    );
        logic signed [AW:0] ym_x;
        logic signed [AW:0] ste_x;
        logic signed [AW:0] sum;
        ym_x  = ym;
        ste_x = ste;
        case (sel)
            2'b00:   sum = (ym_x >>> 2) + ste_x;
            2'b01:   sum = ym_x + ste_x;
            default: sum = ste_x;
        endcase
        // Overflow shows as the two top bits disagreeing; clamp toward the sign.
        if (sum[AW] != sum[AW-1])
            return {sum[AW], {(AW-1){~sum[AW]}}};
        return sum[AW-1:0];
    endfunction

    function automatic logic signed [AW-1:0] attenuate(
        input logic signed [AW-1:0] mix,
        input logic [15:0]          gain
    );
        logic signed [31:0] mix_x;
        logic signed [31:0] gain_x;
        logic signed [31:0] prod;
        mix_x  = mix;
        gain_x = {16'b0, gain};
        prod   = mix_x * gain_x;
        return AW'(prod >>> 15);
    endfunction

    logic signed [AW-1:0] mix_l_q;
    logic signed [AW-1:0] mix_r_q;

    always_ff @(posedge clk_8) begin
        if (reset) begin
            mix_l_q     <= '0;
            mix_r_q     <= '0;
            audio_out_l <= '0;
            audio_out_r <= '0;
        end else begin
            mix_l_q     <= mix_sat(settings_q.mixer, ym_in_l, ste_in_l);
            mix_r_q     <= mix_sat(settings_q.mixer, ym_in_r, ste_in_r);
            audio_out_l <= attenuate(mix_l_q, gain_l_q);
            audio_out_r <= attenuate(mix_r_q, gain_r_q);
        end
    end

endmodule

// File: tb/tb_lmc1992.sv
// Self-checking bench for lmc1992: vector tables, hand-written microwire
// sequences and randomized audio/commands against a behavioural model.
module tb_lmc1992;

    logic clk_8 = 1'b0;
    logic reset = 1'b1;

    lmc1992_if mw_if ();

    logic signed [14:0] ym_l, ym_r, ste_l, ste_r;
    logic signed [14:0] out_l, out_r;
    logic [3:0]         bass, treble;
    logic [1:0]         mixer;
    logic               cmd_strobe;

    lmc1992 dut (
        .clk_8       (clk_8),
        .reset       (reset),
        .mw          (mw_if),
        .ym_in_l     (ym_l),
        .ym_in_r     (ym_r),
        .ste_in_l    (ste_l),
        .ste_in_r    (ste_r),
        .audio_out_l (out_l),
        .audio_out_r (out_r),
        .bass        (bass),
        .treble      (treble),
        .mixer       (mixer),
        .cmd_strobe  (cmd_strobe)
    );

    always #5 clk_8 = ~clk_8;

    typedef struct {
        int ym_l, ym_r, ste_l, ste_r, exp_l, exp_r;
    } mix_vec_t;

    typedef struct {
        logic [15:0] word;
        int nbits, exp_strobes, exp_mixer, exp_bass, exp_treble;
    } cmd_vec_t;

    mix_vec_t mix_tab[6];
    cmd_vec_t cmd_tab[11];
    int gtab[61];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_8);
            #1;
        end
    endtask

    task automatic drive(input int yl, input int yr, input int sl, input int sr);
        ym_l  = 15'(yl);
        ym_r  = 15'(yr);
        ste_l = 15'(sl);
        ste_r = 15'(sr);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        mw_if.mw_en   = 1'b0;
        mw_if.mw_clk  = 1'b0;
        mw_if.mw_data = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] word, input int nbits, output int strobes);
        strobes      = 0;
        mw_if.mw_en  = 1'b1;
        mw_if.mw_clk = 1'b0;
        step(1);
        for (int i = nbits - 1; i >= 0; i--) begin
            mw_if.mw_data = word[i];
            mw_if.mw_clk  = 1'b1;
            step(1);
            strobes += int'(cmd_strobe);
            mw_if.mw_clk = 1'b0;
            step(1);
            strobes += int'(cmd_strobe);
        end
    endtask

    task automatic end_frame(output int s0, output int s1, output int s2);
        mw_if.mw_en = 1'b0;
        step(1);
        s0 = int'(cmd_strobe);
        step(1);
        s1 = int'(cmd_strobe);
        step(1);
        s2 = int'(cmd_strobe);
    endtask

    task automatic send_frame(input logic [15:0] word, input int nbits, output int strobes);
        int pre, a, b, c;
        send_bits(word, nbits, pre);
        end_frame(a, b, c);
        strobes = pre + a + b + c;
    endtask

    function automatic int model_mix(input int mx, input int ym, input int ste);
        int s;
        if (mx == 0)      s = (ym >>> 2) + ste;
        else if (mx == 1) s = ym + ste;
        else              s = ste;
        if (s > 16383)  s = 16383;
        if (s < -16384) s = -16384;
        return s;
    endfunction

    function automatic int model_out(input int mix, input int gain);
        longint p;
        p = longint'(mix) * longint'(gain);
        return int'(p >>> 15);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        real r;
        int s, s0, s1, s2, pre;
        int m_master, m_left, m_right, m_mixer;
        int exp_l_q[$];
        int exp_r_q[$];

        mix_tab[0] = '{0, 0, 4096, 4096, 4096, 4096};
        mix_tab[1] = '{12288, 12288, 12288, 12288, 16383, 16383};
        mix_tab[2] = '{-12288, -12288, -12288, -12288, -16384, -16384};
        mix_tab[3] = '{1000, -3000, -3000, 1000, -2000, -2000};
        mix_tab[4] = '{16383, -16384, 1, -1, 16383, -16384};
        mix_tab[5] = '{100, 0, -100, 5, 0, 5};

        cmd_tab[0]  = '{16'h00E5, 11, 0, 1, 6, 6};
        cmd_tab[1]  = '{16'h04E5, 10, 0, 1, 6, 6};
        cmd_tab[2]  = '{16'h0585, 11, 0, 1, 6, 6};
        cmd_tab[3]  = '{16'h05C3, 11, 0, 1, 6, 6};
        cmd_tab[4]  = '{16'h0445, 11, 1, 1, 5, 6};
        cmd_tab[5]  = '{16'h044F, 11, 1, 1, 12, 6};
        cmd_tab[6]  = '{16'h04BF, 11, 1, 1, 12, 12};
        cmd_tab[7]  = '{16'h0480, 11, 1, 1, 12, 0};
        cmd_tab[8]  = '{16'h0403, 11, 1, 3, 12, 0};
        cmd_tab[9]  = '{16'h0401, 11, 1, 1, 12, 0};
        cmd_tab[10] = '{16'h1447, 13, 1, 1, 7, 0};

        r = 32768.0;
        for (int k = 0; k <= 60; k++) begin
            gtab[k] = $rtoi(r + 0.5);
            r = r * 0.7943282347242815;
        end

        // Reset state and two-clock pipeline latency.
        drive(0, 0, 4096, 4096);
        do_reset();
        reset = 1'b1;
        step(1);
        check("reset out_l", int'(out_l), 0);
        check("reset out_r", int'(out_r), 0);
        check("reset strobe", int'(cmd_strobe), 0);
        check("reset bass", int'(bass), 6);
        check("reset treble", int'(treble), 6);
        check("reset mixer", int'(mixer), 1);
        reset = 1'b0;
        step(1);
        check("post-reset 1clk out_l", int'(out_l), 0);
        step(1);
        check("post-reset 2clk out_l", int'(out_l), 4096);
        check("post-reset 2clk out_r", int'(out_r), 4096);

        foreach (mix_tab[i]) begin
            drive(mix_tab[i].ym_l, mix_tab[i].ym_r, mix_tab[i].ste_l, mix_tab[i].ste_r);
            step(2);
            check($sformatf("mix vec %0d out_l", i), int'(out_l), mix_tab[i].exp_l);
            check($sformatf("mix vec %0d out_r", i), int'(out_r), mix_tab[i].exp_r);
        end

        do_reset();
        drive(0, 0, 4096, 4096);
        foreach (cmd_tab[i]) begin
            send_frame(cmd_tab[i].word, cmd_tab[i].nbits, s);
            check($sformatf("cmd vec %0d strobes", i), s, cmd_tab[i].exp_strobes);
            check($sformatf("cmd vec %0d mixer", i), int'(mixer), cmd_tab[i].exp_mixer);
            check($sformatf("cmd vec %0d bass", i), int'(bass), cmd_tab[i].exp_bass);
            check($sformatf("cmd vec %0d treble", i), int'(treble), cmd_tab[i].exp_treble);
            check($sformatf("cmd vec %0d out_l", i), int'(out_l), 4096);
        end

        // Master 37: strobe on the frame-end edge, gain one edge later, output one more.
        do_reset();
        drive(0, 0, 4096, 4096);
        step(2);
        send_bits(16'h04E5, 11, pre);
        check("master pre-end strobes", pre, 0);
        mw_if.mw_en = 1'b0;
        step(1);
        check("master E1 strobe", int'(cmd_strobe), 1);
        check("master E1 out_l", int'(out_l), 4096);
        step(1);
        check("master E2 strobe", int'(cmd_strobe), 0);
        check("master E2 out_l", int'(out_l), 4096);
        step(1);
        check("master E3 out_l", int'(out_l), 2052);
        check("master E3 out_r", int'(out_r), 2052);

        do_reset();
        send_frame(16'h054A, 11, s);
        check("left10 strobes", s, 1);
        check("left10 out_l", int'(out_l), 409);
        check("left10 out_r", int'(out_r), 4096);

        do_reset();
        drive(8000, 8000, 0, 0);
        send_frame(16'h0402, 11, s);
        check("mixer10 out_l", int'(out_l), 0);
        check("mixer10 out_r", int'(out_r), 0);
        send_frame(16'h0400, 11, s);
        check("mixer00 out_l", int'(out_l), 2000);
        check("mixer00 out_r", int'(out_r), 2000);

        // Reset in the middle of a frame, then a clean frame.
        do_reset();
        drive(0, 0, 4096, 4096);
        send_bits(16'h0445, 5, pre);
        reset         = 1'b1;
        mw_if.mw_en   = 1'b0;
        mw_if.mw_clk  = 1'b0;
        step(2);
        check("midframe reset out_l", int'(out_l), 0);
        reset = 1'b0;
        send_frame(16'h04E5, 11, s);
        check("midframe recover strobes", s, 1);
        check("midframe recover bass", int'(bass), 6);
        check("midframe recover out_l", int'(out_l), 2052);
        check("midframe recover out_r", int'(out_r), 2052);

        // Randomized commands and audio against the reference model.
        do_reset();
        m_master = 40;
        m_left   = 20;
        m_right  = 20;
        m_mixer  = 1;
        for (int round = 0; round < 12; round++) begin
            int sel, cmd, v, gl, gr;
            logic [2:0] c3;
            logic [5:0] v6;
            sel = int'($urandom_range(3));
            cmd = (sel == 0) ? 0 : sel + 2;
            v   = int'($urandom_range(63));
            c3  = 3'(cmd);
            v6  = 6'(v);
            send_frame({5'b0, 2'b10, c3, v6}, 11, s);
            check("rand strobes", s, 1);
            case (cmd)
                0:       m_mixer  = v % 4;
                3:       m_master = imin(v, 40);
                4:       m_right  = imin(v, 20);
                default: m_left   = imin(v, 20);
            endcase
            check("rand mixer", int'(mixer), m_mixer);
            gl = gtab[(40 - m_master) + (20 - m_left)];
            gr = gtab[(40 - m_master) + (20 - m_right)];
            for (int i = 0; i <= 24; i++) begin
                if (i < 24) begin
                    int yl, yr, sl, sr;
                    yl = int'($urandom_range(32767)) - 16384;
                    yr = int'($urandom_range(32767)) - 16384;
                    sl = int'($urandom_range(32767)) - 16384;
                    sr = int'($urandom_range(32767)) - 16384;
                    drive(yl, yr, sl, sr);
                    exp_l_q.push_back(model_out(model_mix(m_mixer, yl, sl), gl));
                    exp_r_q.push_back(model_out(model_mix(m_mixer, yr, sr), gr));
                end
                step(1);
                if (i >= 1) begin
                    check("rand out_l", int'(out_l), exp_l_q.pop_front());
                    check("rand out_r", int'(out_r), exp_r_q.pop_front());
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
